// File: rtl/timer_sched_ctrl.sv
// Countdown-timer sequencer: 0.1 ms tick prescaler, start/pause/restart FSM,
// and round-robin arbitration of penalty requests onto the remaining-time register.
module timer_sched_ctrl #(
    parameter int unsigned TICK_DIV   = 5000,
    parameter int unsigned START_TIME = 1800000,
    parameter int unsigned PENALTY    = 10000,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned TW         = 24
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic            pause,
    input  logic            restart,
    input  logic [NREQ-1:0] miss_req,
    output logic [NREQ-1:0] miss_ack,
    output logic [TW-1:0]   time_left,
    output logic            tick,
    output logic [1:0]      state,
    output logic            game_fail
);

    localparam int unsigned PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PW  = $clog2(NREQ);

    localparam logic [PSW-1:0] PRESC_LAST = PSW'(TICK_DIV - 1);
    localparam logic [TW-1:0]  TIME_INIT  = TW'(START_TIME);
    localparam logic [TW-1:0]  TIME_PEN   = TW'(PENALTY);
    localparam logic [PW-1:0]  PTR_LAST   = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_FAIL  = 2'b11
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PSW-1:0]  presc_q;
    logic [PSW-1:0]  presc_d;
    logic [NREQ-1:0] pend_q;
    logic [NREQ-1:0] pend_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [TW-1:0]   time_d;
    logic [NREQ-1:0] ack_d;
    logic            tick_d;
    logic            fail_d;

    logic            run;
    logic            tick_event;
    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [TW-1:0]   dec;
    logic [TW-1:0]   time_sub;

    assign run        = (state_q == ST_RUN);
    assign tick_event = run && (presc_q == PRESC_LAST);

    // Round-robin pick: first pending requester at or after the pointer.
    always_comb begin : arbiter
        int pos;
        pos       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= int'(NREQ)) begin
                pos = pos - int'(NREQ);
            end
            if (run && !grant_vld && pend_q[PW'(pos)]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(pos);
            end
        end
        grant_oh = grant_vld ? (NREQ'(1) << grant_idx) : '0;
    end

    // Combined tick + penalty decrement, saturating at zero.
    assign dec      = TW'(tick_event) + (grant_vld ? TIME_PEN : '0);
    assign time_sub = (time_left > dec) ? (time_left - dec) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (restart) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_RUN;
                ST_RUN: begin
                    if (time_sub == '0) begin
                        state_d = ST_FAIL;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (start && !pause) state_d = ST_RUN;
                default:  state_d = ST_FAIL;
            endcase
        end
    end

    always_comb begin : datapath
        presc_d = presc_q;
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        time_d  = time_left;
        ack_d   = '0;
        tick_d  = 1'b0;
        fail_d  = (state_d == ST_FAIL);
        if (restart) begin
            presc_d = '0;
            pend_d  = '0;
            ptr_d   = '0;
            time_d  = TIME_INIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    time_d = TIME_INIT;
                    pend_d = '0;
                    if (start) presc_d = '0;
                end
                ST_RUN: begin
                    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PSW'(1);
                    time_d  = time_sub;
                    tick_d  = tick_event;
                    ack_d   = grant_oh;
                    if (grant_vld) begin
                        ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + PW'(1);
                    end
                    // A new request in the grant cycle survives the clear.
                    pend_d = (pend_q & ~grant_oh) | miss_req;
                    if (state_d == ST_FAIL) pend_d = '0;
                end
                ST_PAUSE: pend_d = pend_q | miss_req;
                default:  pend_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            pend_q    <= '0;
            ptr_q     <= '0;
            time_left <= TIME_INIT;
            miss_ack  <= '0;
            tick      <= 1'b0;
            game_fail <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            time_left <= time_d;
            miss_ack  <= ack_d;
            tick      <= tick_d;
            game_fail <= fail_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Bench for timer_sched_ctrl: hand-derived vector table, directed corner
// sequences and random stimulus, all checked against a cycle model.
module tb_timer_sched_ctrl;

    localparam int unsigned TD  = 4;
    localparam int unsigned ST0 = 100;
    localparam int unsigned PEN = 3;
    localparam int unsigned NR  = 4;
    localparam int unsigned TWB = 16;

    logic           clock    = 1'b0;
    logic           reset_n  = 1'b0;
    logic           start    = 1'b0;
    logic           pause    = 1'b0;
    logic           restart  = 1'b0;
    logic [NR-1:0]  miss_req = '0;
    logic [NR-1:0]  miss_ack;
    logic [TWB-1:0] time_left;
    logic           tick;
    logic [1:0]     state;
    logic           game_fail;

    timer_sched_ctrl #(
        .TICK_DIV(TD), .START_TIME(ST0), .PENALTY(PEN), .NREQ(NR), .TW(TWB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .pause(pause),
        .restart(restart), .miss_req(miss_req), .miss_ack(miss_ack),
        .time_left(time_left), .tick(tick), .state(state), .game_fail(game_fail)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    int            m_state;
    int            m_time;
    int            m_pre;
    int            m_ptr;
    logic [NR-1:0] m_pend;
    logic [NR-1:0] e_ack;
    logic          e_tick;

    typedef struct {
        logic           st;
        logic           pa;
        logic           rs;
        logic [NR-1:0]  req;
        logic [1:0]     e_st;
        logic [TWB-1:0] e_time;
        logic           e_tk;
        logic [NR-1:0]  e_ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic pa, input logic rs,
                                input logic [NR-1:0] req, input logic [1:0] es,
                                input logic [TWB-1:0] et, input logic etk,
                                input logic [NR-1:0] ea);
        vec_t v;
        v.st = st; v.pa = pa; v.rs = rs; v.req = req;
        v.e_st = es; v.e_time = et; v.e_tk = etk; v.e_ack = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_time = int'(ST0); m_pre = 0; m_ptr = 0;
        m_pend = '0; e_ack = '0; e_tick = 1'b0;
    endtask

    // Behavioural reference: one clock of the game rules in integer arithmetic.
    task automatic model_step(input logic st, input logic pa, input logic rs,
                              input logic [NR-1:0] req);
        int g;
        int d;
        int idx;
        e_ack  = '0;
        e_tick = 1'b0;
        if (rs) begin
            model_reset();
        end else begin
            case (m_state)
                0: if (st) begin m_state = 1; m_pre = 0; end
                1: begin
                    e_tick = (m_pre == int'(TD) - 1);
                    m_pre  = (m_pre + 1) % int'(TD);
                    g = -1;
                    for (int k = 0; k < int'(NR); k++) begin
                        idx = (m_ptr + k) % int'(NR);
                        if (g < 0 && m_pend[2'(idx)]) g = idx;
                    end
                    d = (e_tick ? 1 : 0) + ((g >= 0) ? int'(PEN) : 0);
                    m_time = (m_time > d) ? m_time - d : 0;
                    if (g >= 0) begin
                        m_pend[2'(g)] = 1'b0;
                        m_ptr = (g + 1) % int'(NR);
                        e_ack[2'(g)] = 1'b1;
                    end
                    m_pend = m_pend | req;
                    if (m_time == 0) begin
                        m_state = 3;
                        m_pend  = '0;
                    end else if (pa) begin
                        m_state = 2;
                    end
                end
                2: begin
                    m_pend = m_pend | req;
                    if (st && !pa) m_state = 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_model();
        check("model_state", 32'(state), 32'(m_state));
        check("model_time", 32'(time_left), 32'(m_time));
        check("model_tick", 32'(tick), 32'(e_tick));
        check("model_ack", 32'(miss_ack), 32'(e_ack));
        check("model_fail", 32'(game_fail), (m_state == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input logic st, input logic pa, input logic rs,
                        input logic [NR-1:0] req);
        start = st; pause = pa; restart = rs; miss_req = req;
        model_step(st, pa, rs, req);
        @(posedge clock);
        #1;
        compare_model();
        start = 1'b0; pause = 1'b0; restart = 1'b0; miss_req = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] ack_seen;
        int            n_ticks;
        int            last_tick;
        int            guard;

        model_reset();
        #12;
        check("reset_state", 32'(state), 32'd0);
        check("reset_time", 32'(time_left), 32'(ST0));
        check("reset_fail", 32'(game_fail), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Hand-derived vectors: TICK_DIV=4, START_TIME=100, PENALTY=3.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd100, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b1111, 2'd1, 16'd100, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd97,  1'b0, 4'b0001));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd94,  1'b0, 4'b0010));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd90,  1'b1, 4'b0100));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd87,  1'b0, 4'b1000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd87,  1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0100, 2'd1, 16'd87,  1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 16'd83,  1'b1, 4'b0100));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0010, 2'd2, 16'd83,  1'b0, 4'b0000));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 16'd83,  1'b0, 4'b0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd83,  1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd80,  1'b0, 4'b0010));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 16'd100, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b1111, 2'd1, 16'd100, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd100, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 2'd1, 16'd100, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0001, 2'd1, 16'd97,  1'b0, 4'b0001));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd93,  1'b1, 4'b0001));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 16'd93,  1'b0, 4'b0000));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].st, tbl[i].pa, tbl[i].rs, tbl[i].req);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].e_st));
            check($sformatf("vec%0d_time", i), 32'(time_left), 32'(tbl[i].e_time));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].e_tk));
            check($sformatf("vec%0d_ack", i), 32'(miss_ack), 32'(tbl[i].e_ack));
        end

        // Long pause with a latched request: nothing moves until resume.
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0100);
        ack_seen = '0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'b0000);
            ack_seen = ack_seen | miss_ack;
        end
        check("pause_no_ack", 32'(ack_seen), 32'd0);
        check("pause_time_frozen", 32'(time_left), 32'd93);
        check("pause_state", 32'(state), 32'd2);
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        check("resume_ack2", 32'(miss_ack), 32'b0100);
        check("resume_time", 32'(time_left), 32'd90);
        check("resume_no_tick_yet", 32'(tick), 32'd0);
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        check("resume_tick_phase", 32'(tick), 32'd1);
        check("resume_tick_time", 32'(time_left), 32'd89);

        // Tick cadence from a fresh start.
        step(1'b0, 1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        n_ticks = 0;
        last_tick = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'b0000);
            if (tick) begin
                if (n_ticks == 0) begin
                    check("first_tick_cycle", 32'(i), 32'd3);
                    check("first_tick_time", 32'(time_left), 32'd99);
                end else begin
                    check("tick_spacing", 32'(i - last_tick), 32'(TD));
                end
                n_ticks++;
                last_tick = i;
            end
        end
        check("five_ticks", 32'(n_ticks), 32'd5);
        check("five_ticks_time", 32'(time_left), 32'd95);

        // Asynchronous reset in the middle of RUN at time_left 7.
        guard = 0;
        while (m_time != 7 && guard < 1000) begin
            step(1'b0, 1'b0, 1'b0, 4'b0000);
            guard++;
        end
        check("reach_time7", 32'(time_left), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_time", 32'(time_left), 32'(ST0));
        check("async_rst_fail", 32'(game_fail), 32'd0);
        check("async_rst_ack", 32'(miss_ack), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        model_reset();
        #3;
        reset_n = 1'b1;

        // Expiry through a penalty larger than the remaining time.
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        guard = 0;
        while (!(m_time == 2 && m_pre == 0) && guard < 1000) begin
            step(1'b0, 1'b0, 1'b0, 4'b0000);
            guard++;
        end
        check("reach_time2", 32'(time_left), 32'd2);
        step(1'b0, 1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        check("expire_time", 32'(time_left), 32'd0);
        check("expire_state", 32'(state), 32'd3);
        check("expire_fail", 32'(game_fail), 32'd1);
        check("expire_ack", 32'(miss_ack), 32'b0001);
        ack_seen = '0;
        step(1'b0, 1'b0, 1'b0, 4'b1111);
        ack_seen = ack_seen | miss_ack;
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        ack_seen = ack_seen | miss_ack;
        step(1'b1, 1'b1, 1'b0, 4'b0000);
        ack_seen = ack_seen | miss_ack;
        check("fail_no_ack", 32'(ack_seen), 32'd0);
        check("fail_sticky", 32'(state), 32'd3);
        check("fail_tick_stopped", 32'(tick), 32'd0);
        step(1'b0, 1'b0, 1'b1, 4'b0000);
        check("restart_state", 32'(state), 32'd0);
        check("restart_time", 32'(time_left), 32'(ST0));
        check("restart_fail", 32'(game_fail), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 6) == 0, ($urandom % 12) == 0, ($urandom % 250) == 0,
                 (($urandom % 4) == 0) ? NR'($urandom) : '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_sched_ctrl.md
Name: timer_sched_ctrl

Overview:
- Sequencing controller for the game countdown timer.
- Owns the 0.1 ms tick prescaler and the start/pause/restart state machine.
- Arbitrates time-penalty (miss) requests from up to NREQ game modules onto the single remaining-time register. Arbitration is round-robin, one penalty applied per cycle.
- Publishes remaining time, the tick strobe, state and the sticky game-fail flag to the display and game logic.

Parameters:
- TICK_DIV, 5000, clock cycles per tick (50 MHz -> 0.1 ms).
- START_TIME, 1800000, initial remaining time in ticks.
- PENALTY, 10000, ticks subtracted per granted miss.
- NREQ, 4, number of penalty requesters (>=2).
- TW, 24, width of the time register (must hold START_TIME).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  start from IDLE, or resume from PAUSE (level, sampled each cycle).
- pause  in  1  pause request while RUN.
- restart  in  1  return to IDLE and reload the timer; highest priority.
- miss_req  in  NREQ  per-requester penalty pulse; one cycle high = one penalty.
- miss_ack  out  NREQ  one-hot, one-cycle pulse when that requester's penalty is applied.
- time_left  out  TW  remaining ticks.
- tick  out  1  one-cycle strobe each elapsed tick while RUN.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 FAIL.
- game_fail  out  1  sticky; high in FAIL.

Behaviour:
- Reset (reset_n low, asynchronous) values:
  - state=IDLE, time_left=START_TIME, prescaler=0, pend=0.
  - RR pointer=0, tick=0, miss_ack=0, game_fail=0.
- restart=1, any state (sync) -> next cycle same values as reset. Overrides all other inputs.
- IDLE:
  - time_left held at START_TIME; miss_req ignored (not latched).
  - start=1 -> RUN, prescaler cleared.
- RUN, prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - In the cycle it equals TICK_DIV-1, the registered tick is 1 on the next cycle and time_left decrements by 1 on that same edge.
- RUN, pause:
  - pause=1 -> PAUSE. Prescaler frozen, no decrement, no grants.
  - pause beats start when both are high.
- PAUSE:
  - start=1 (pause=0) -> RUN; prescaler resumes from its frozen value.
  - miss_req still latched into pend.
- Pending latch:
  - pend[i] is set by miss_req[i] in RUN and PAUSE.
  - A penalty is never lost while pend is already set only if the new request arrives in the grant cycle: set wins over clear, so pend[i] stays 1.
  - Multiple pulses while pend[i] is already 1 and not granted collapse to one penalty.
- Arbitration (RUN only):
  - Each cycle, grant the first pend bit at or after the RR pointer, wrapping modulo NREQ.
  - Clear that pend bit.
  - Pointer <- granted index + 1 mod NREQ.
  - miss_ack[granted] = 1 on the next cycle.
  - At most one grant per cycle.
- Arithmetic:
  - Decrement d = (tick event ? 1 : 0) + (grant ? PENALTY : 0).
  - time_left <= (time_left > d) ? time_left - d : 0.
  - Saturating, never wraps below 0.
- Expiry:
  - When time_left becomes 0 in RUN, state -> FAIL on the same edge.
  - game_fail=1, tick stops, pend cleared, further miss_req ignored.
- FAIL: only restart or reset exits; start and pause ignored.
- Outputs tick and miss_ack are registered; time_left is visible one cycle after the causing event.

Test Plan:
- Reset behaviour: assert reset_n=0 mid-RUN with time_left=7 -> immediately state=00, time_left=START_TIME, game_fail=0, miss_ack=0.
- Tick count (TICK_DIV=4, START_TIME=20): pulse start -> tick every 4 cycles. time_left 19 after the first tick, 15 after five ticks.
- Round-robin (NREQ=4, PENALTY=3, START_TIME=100): miss_req=1111 for one cycle in RUN -> acks 0001, 0010, 0100, 1000 on consecutive cycles; time_left=88 absent ticks.
- Simultaneous events: grant and tick on the same edge with time_left=50, PENALTY=3 -> 46. A same-index re-request in the grant cycle -> a second ack follows.
- Pause: pause while pend[2]=1 -> no ack, time_left frozen for 100 cycles. start -> ack[2] issued, ticks resume at the preserved prescaler phase.
- Expiry: time_left=2, PENALTY=3, grant -> time_left=0, state=11, game_fail=1. Further miss_req gives no ack. restart -> IDLE, time_left=START_TIME.
